// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 raster timing, frame-buffer read addressing and RGB444/sync output stage.
// Latency: colour, hsync, vsync and vblank trail the counters by 2 clk (1 clk BRAM read + output reg).
// Backpressure: none; free-running raster. en=0 parks the counters at (0,0) and drives idle outputs.
module vga_scanout #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] fg_color,
    input  logic [11:0] bg_color,
    output logic [18:0] fb_raddr,
    input  logic        fb_rdata,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vblank,
    output logic        frame_start
);

    // Raster geometry folded into the 10-bit counter domain.
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // With CLK_DIV=1 the divider collapses to a single bit that never leaves 0,
    // so the tick compare is permanently true.
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic [18:0]      r_addr;
    logic             r_frame_start;

    // Stage 1: raw timing flags, one clk behind the counters (in step with the BRAM read).
    logic             r_de1;
    logic             r_hs1;
    logic             r_vs1;
    logic             r_vb1;

    // Stage 2: the registered pin drivers.
    logic [11:0]      r_rgb;
    logic             r_hs2;
    logic             r_vs2;
    logic             r_vb2;

    logic             w_tick;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_wrap;
    logic             w_de_raw;
    logic             w_hs_raw;
    logic             w_vs_raw;
    logic             w_vblank_raw;

    assign w_tick       = (r_div_cnt == DIV_LAST);
    assign w_h_last     = (r_h == H_LAST);
    assign w_v_last     = (r_v == V_LAST);
    assign w_wrap       = w_h_last && w_v_last;

    assign w_de_raw     = (r_h < H_VIS_END) && (r_v < V_VIS_END);
    assign w_hs_raw     = !((r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END));
    assign w_vs_raw     = !((r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END));
    assign w_vblank_raw = (r_v >= V_VIS_END);

    // Pixel-rate divider: counts system clocks within one pixel slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (!en || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Horizontal counter: one step per pixel tick, wrapping at the end of the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
        end else if (!en) begin
            r_h <= '0;
        end else if (w_tick) begin
            r_h <= w_h_last ? 10'd0 : r_h + 10'd1;
        end
    end

    // Vertical counter: advances on the tick that wraps the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
        end else if (!en) begin
            r_v <= '0;
        end else if (w_tick && w_h_last) begin
            r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
        end
    end

    // Linear read address: counts visible pixels only, so it equals v*H_VISIBLE+h
    // inside the picture without a multiplier and parks one past the end in vblank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (!en) begin
            r_addr <= '0;
        end else if (w_tick) begin
            if (w_wrap) begin
                r_addr <= '0;
            end else if (w_de_raw) begin
                r_addr <= r_addr + 19'd1;
            end
        end
    end

    // Frame marker: tracks the counter wrap itself, not the delayed pixel stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= en && w_tick && w_wrap;
        end
    end

    // Stage 1: capture timing flags alongside the BRAM read; idle flags while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de1 <= 1'b0;
            r_hs1 <= 1'b1;
            r_vs1 <= 1'b1;
            r_vb1 <= 1'b0;
        end else if (!en) begin
            r_de1 <= 1'b0;
            r_hs1 <= 1'b1;
            r_vs1 <= 1'b1;
            r_vb1 <= 1'b0;
        end else begin
            r_de1 <= w_de_raw;
            r_hs1 <= w_hs_raw;
            r_vs1 <= w_vs_raw;
            r_vb1 <= w_vblank_raw;
        end
    end

    // Stage 2: colour lookup from the returned pixel bit; black outside the picture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= 12'h000;
            r_hs2 <= 1'b1;
            r_vs2 <= 1'b1;
            r_vb2 <= 1'b0;
        end else begin
            r_rgb <= r_de1 ? (fb_rdata ? fg_color : bg_color) : 12'h000;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            r_vb2 <= r_vb1;
        end
    end

    assign fb_raddr    = r_addr;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign vga_hs      = r_hs2;
    assign vga_vs      = r_vs2;
    assign vblank      = r_vb2;
    assign frame_start = r_frame_start;

endmodule
